// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_unit_pkg;

    localparam int unsigned XLEN        = 32;
    localparam int unsigned INSTR_BYTES = 4;

    // One buffered fetch result: the word and the address it came from.
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_pkt_t;

    // Force an address onto an instruction-word boundary.
    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
        return pc & ~(XLEN'(INSTR_BYTES) - XLEN'(1));
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetch packets. The head entry is read straight out of
// the storage array, so decode sees data the cycle after it is written.
module fetch_fifo
    import fetch_unit_pkg::*;
#(
    parameter  int unsigned DEPTH = 2,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush_i,
    input  logic             push_i,
    input  fetch_pkt_t       push_data_i,
    input  logic             pop_i,
    output fetch_pkt_t       head_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);

    fetch_pkt_t       mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    // A push into a full FIFO is allowed when the head leaves in the same cycle.
    assign do_pop  = pop_i & ~empty_o & ~flush_i;
    assign do_push = push_i & (~full_o | do_pop) & ~flush_i;

    // Next-state for pointers and occupancy; flush discards everything.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values regardless of statement order.
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Packet storage, written at the tail pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: storage is reset only because the head drives dec_pc/dec_instr, which must read zero in reset; deeper buffers would leave it unreset.
            for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, issues credit-limited requests to
// instruction memory, buffers {pc, instr} pairs for decode and discards stale
// words after a redirect.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        dec_valid,
    input  logic        dec_ready,
    output logic [31:0] dec_instr,
    output logic [31:0] dec_pc
);

    localparam int unsigned     CNT_W   = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned     SUM_W   = CNT_W + 1;
    localparam logic [XLEN-1:0] PC_STEP = XLEN'(INSTR_BYTES);

    logic [XLEN-1:0]  fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0]  rsp_pc_q, rsp_pc_d;
    logic [CNT_W-1:0] outstanding_q, outstanding_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
    logic             run_q;

    logic [CNT_W-1:0] fifo_count;
    logic             fifo_full;
    logic             fifo_empty;
    fetch_pkt_t       fifo_head;
    fetch_pkt_t       push_pkt;

    logic [SUM_W-1:0] in_use;
    logic             credit_ok;
    logic             req_fire;
    logic             rsp_keep;
    logic             pop;
    logic [XLEN-1:0]  redirect_target;

    assign redirect_target = align_pc(redirect_pc);

    // Buffered words plus in-flight requests; each request holds a slot until its
    // word lands or is dropped, so a kept response always finds space.
    assign in_use    = {1'b0, fifo_count} + {1'b0, outstanding_q};
    assign credit_ok = (in_use < SUM_W'(FIFO_DEPTH));

    // run_q keeps the request channel quiet until the first edge after reset release.
    assign imem_req_valid = run_q & ~redirect_valid & credit_ok;
    assign imem_req_addr  = fetch_pc_q;
    assign req_fire       = imem_req_valid & imem_req_ready;

    // Stale words are discarded while drop_cnt counts down; a redirect cycle drops too.
    assign rsp_keep = imem_rsp_valid & ~redirect_valid & (drop_cnt_q == '0);
    assign push_pkt = '{pc: rsp_pc_q, instr: imem_rsp_data};

    assign dec_valid = ~fifo_empty & ~redirect_valid;
    assign dec_pc    = fifo_head.pc;
    assign dec_instr = fifo_head.instr;
    assign pop       = dec_valid & dec_ready;

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush_i     (redirect_valid),
        .push_i      (rsp_keep),
        .push_data_i (push_pkt),
        .pop_i       (pop),
        .head_o      (fifo_head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count)
    );

    // Next-state for PCs and request accounting; a redirect overrides everything.
    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        rsp_pc_d      = rsp_pc_q;
        outstanding_d = outstanding_q + CNT_W'(req_fire) - CNT_W'(imem_rsp_valid);
        drop_cnt_d    = drop_cnt_q;
        if (redirect_valid) begin
            fetch_pc_d = redirect_target;
            rsp_pc_d   = redirect_target;
            // Everything still in flight after this cycle belongs to the old stream.
            // outstanding already covers words an earlier redirect marked stale,
            // so back-to-back redirects accumulate without double counting.
            drop_cnt_d = outstanding_q - CNT_W'(imem_rsp_valid);
        end else begin
            if (req_fire) fetch_pc_d = fetch_pc_q + PC_STEP;
            if (rsp_keep) begin
                rsp_pc_d = rsp_pc_q + PC_STEP;
            end else if (imem_rsp_valid) begin
                drop_cnt_d = drop_cnt_q - CNT_W'(1);
            end
        end
    end

    // Fetch state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_q    <= RESET_PC;
            rsp_pc_q      <= RESET_PC;
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
            run_q         <= 1'b0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            rsp_pc_q      <= rsp_pc_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
            run_q         <= 1'b1;
        end
    end

    // Credit accounting must never over-commit the buffer; memory only answers requests.
    a_credit : assert property (@(posedge clk) disable iff (!rst_n)
        in_use <= SUM_W'(FIFO_DEPTH));
    a_no_orphan_rsp : assert property (@(posedge clk) disable iff (!rst_n)
        imem_rsp_valid |-> (outstanding_q != '0));
    a_push_space : assert property (@(posedge clk) disable iff (!rst_n)
        rsp_keep |-> (!fifo_full || pop));

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: random memory/decode/redirect traffic
// against a transaction-level model of the fetch stream.
module tb_fetch_unit;

    localparam int unsigned DEPTH  = 2;
    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        dec_valid;
    logic        dec_ready = 1'b0;
    logic [31:0] dec_instr;
    logic [31:0] dec_pc;

    fetch_unit #(
        .RESET_PC   (RST_PC),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .dec_valid      (dec_valid),
        .dec_ready      (dec_ready),
        .dec_instr      (dec_instr),
        .dec_pc         (dec_pc)
    );

    always #5 clk = ~clk;

    // Memory-side request in flight: address, cycle its word returns, stream epoch.
    typedef struct {
        logic [31:0] addr;
        int          due;
        int          epoch;
    } mem_req_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } dec_ent_t;

    mem_req_t    mem_q[$];
    dec_ent_t    dec_q[$];
    logic [31:0] next_addr;
    int          epoch;
    int          cyc;
    int          last_due;
    int          n_cmp;
    int          n_bad;
    int          n_pop;
    int          first_req;
    int          first_dv;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Contents of instruction memory at a given address.
    function automatic logic [31:0] word_of(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic drive_idle();
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        dec_ready      = 1'b0;
    endtask

    // Assert reset for some cycles, checking outputs, then release; memory side is cleared too.
    task automatic apply_reset(input int cycles);
        @(negedge clk);
        rst_n = 1'b0;
        drive_idle();
        mem_q.delete();
        dec_q.delete();
        next_addr = RST_PC;
        epoch++;
        for (int i = 0; i < cycles; i++) begin
            #1;
            check("rst_req_valid", 32'(imem_req_valid), 32'd0);
            check("rst_dec_valid", 32'(dec_valid), 32'd0);
            check("rst_dec_pc", dec_pc, 32'd0);
            check("rst_dec_instr", dec_instr, 32'd0);
            @(negedge clk);
            cyc++;
        end
        rst_n = 1'b1;
        @(posedge clk);
        cyc++;
    endtask

    // One clock cycle: drive inputs, check outputs against the model, advance the model.
    task automatic do_cycle(input bit rq_rdy, input bit dc_rdy, input bit redir,
                            input logic [31:0] rpc, input int lat);
        bit       rsp;
        bit       exp_rv;
        bit       exp_dv;
        bit       req_acc;
        bit       pop;
        mem_req_t m;
        int       due;
        @(negedge clk);
        rsp = (mem_q.size() > 0) && (mem_q[0].due == cyc);
        imem_req_ready = rq_rdy;
        dec_ready      = dc_rdy;
        redirect_valid = redir;
        redirect_pc    = rpc;
        imem_rsp_valid = rsp;
        imem_rsp_data  = rsp ? word_of(mem_q[0].addr) : $urandom;
        #1;
        exp_rv = !redir && ((dec_q.size() + mem_q.size()) < DEPTH);
        check("req_valid", 32'(imem_req_valid), 32'(exp_rv));
        if (exp_rv) check("req_addr", imem_req_addr, next_addr);
        exp_dv = !redir && (dec_q.size() > 0);
        check("dec_valid", 32'(dec_valid), 32'(exp_dv));
        if (exp_dv) begin
            check("dec_pc", dec_pc, dec_q[0].pc);
            check("dec_instr", dec_instr, dec_q[0].instr);
        end
        req_acc = imem_req_valid && rq_rdy && !redir;
        pop     = dec_valid && dc_rdy;
        if (req_acc && first_req < 0) first_req = cyc;
        if (dec_valid && first_dv < 0) first_dv = cyc;
        if (pop && dec_q.size() > 0) begin
            void'(dec_q.pop_front());
            n_pop++;
        end
        if (rsp) begin
            m = mem_q.pop_front();
            if (!redir && m.epoch == epoch) dec_q.push_back('{pc: m.addr, instr: word_of(m.addr)});
        end
        if (redir) begin
            dec_q.delete();
            epoch++;
            next_addr = rpc & ~32'h3;
        end else if (req_acc) begin
            due = cyc + lat;
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            mem_q.push_back('{addr: imem_req_addr, due: due, epoch: epoch});
            next_addr = next_addr + 32'd4;
        end
        cyc++;
    endtask

    initial begin
        n_cmp = 0; n_bad = 0; n_pop = 0;
        cyc = 0; last_due = 0; epoch = 0;
        first_req = -1; first_dv = -1;
        next_addr = RST_PC;

        apply_reset(3);

        // Streaming with single-cycle memory: sequential addresses, two-cycle fill latency.
        repeat (30) do_cycle(1'b1, 1'b1, 1'b0, 32'h0, 1);
        check("first_dec_latency", 32'(first_dv - first_req), 32'd2);

        // Decode stalled: requests stop once the buffer is committed, then drain in order.
        repeat (10) do_cycle(1'b1, 1'b0, 1'b0, 32'h0, 1);
        repeat (10) do_cycle(1'b1, 1'b1, 1'b0, 32'h0, 1);

        // Memory not ready with a request pending: address must hold.
        repeat (3) do_cycle(1'b0, 1'b1, 1'b0, 32'h0, 1);
        repeat (5) do_cycle(1'b1, 1'b1, 1'b0, 32'h0, 1);

        // Redirect with two requests in flight at latency 3.
        for (int i = 0; i < 20 && mem_q.size() != 2; i++) do_cycle(1'b1, 1'b1, 1'b0, 32'h0, 3);
        do_cycle(1'b1, 1'b1, 1'b1, 32'h100, 3);
        repeat (15) do_cycle(1'b1, 1'b1, 1'b0, 32'h0, 3);

        // Redirect with a full buffer, then again with nothing buffered or in flight.
        for (int i = 0; i < 20 && dec_q.size() < DEPTH; i++) do_cycle(1'b1, 1'b0, 1'b0, 32'h0, 1);
        do_cycle(1'b1, 1'b0, 1'b1, 32'h40, 1);
        do_cycle(1'b1, 1'b1, 1'b1, 32'h80, 1);
        repeat (6) do_cycle(1'b1, 1'b1, 1'b0, 32'h0, 2);

        // Redirect in the same cycle a response arrives.
        for (int i = 0; i < 20 && !(mem_q.size() > 0 && mem_q[0].due == cyc); i++)
            do_cycle(1'b1, 1'b1, 1'b0, 32'h0, 2);
        do_cycle(1'b1, 1'b1, 1'b1, 32'h200, 2);
        repeat (10) do_cycle(1'b1, 1'b1, 1'b0, 32'h0, 2);

        // Address wrap and forced alignment of the redirect target.
        do_cycle(1'b1, 1'b1, 1'b1, 32'hFFFF_FFF8, 1);
        repeat (8) do_cycle(1'b1, 1'b1, 1'b0, 32'h0, 1);
        do_cycle(1'b1, 1'b1, 1'b1, 32'h0000_0103, 1);
        repeat (8) do_cycle(1'b1, 1'b1, 1'b0, 32'h0, 1);

        // Random traffic: ready jitter, variable latency, occasional redirects.
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] tgt;
            tgt = $urandom;
            if ($urandom_range(3) == 0) tgt = 32'hFFFF_FFF0 | (tgt & 32'hF);
            do_cycle($urandom_range(99) < 75, $urandom_range(99) < 70,
                     $urandom_range(99) < 3, tgt, int'($urandom_range(4, 1)));
        end

        // Reset in the middle of traffic, then continue.
        for (int i = 0; i < 20 && mem_q.size() == 0; i++) do_cycle(1'b1, 1'b0, 1'b0, 32'h0, 3);
        apply_reset(2);
        for (int i = 0; i < 500; i++) begin
            do_cycle($urandom_range(99) < 75, $urandom_range(99) < 70,
                     $urandom_range(99) < 3, $urandom, int'($urandom_range(4, 1)));
        end

        check("progress", 32'(n_pop > 500), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
